mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between two requesters: the CPU datapath (fetch and data accesses) and a debug/program-loader port.
- Registered-owner FSM with a bounded-burst fairness rule.
- Fixed one-cycle read latency; read data is routed back to the requester that issued the read.
- Sits between the datapath's memory-address mux and the memory file, and tells the control FSM when to stall.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MAX_HOLD, 4, maximum consecutive accepted accesses by one owner while the other requester waits; minimum 1.

Ports:
- CLK  input  1  clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU access request; held with addr/we/wdata stable until granted.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_gnt  output  1  CPU access accepted this cycle.
- cpu_stall  output  1  cpu_req & ~cpu_gnt; drives the control FSM's wait.
- cpu_rvalid  output  1  CPU read data valid.
- cpu_rdata  output  DATA_W  CPU read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/ADDR_W/DATA_W  debug port; same rules as the CPU port.
- dbg_gnt  output  1  debug access accepted.
- dbg_rvalid  output  1  debug read data valid.
- dbg_rdata  output  DATA_W  debug read data.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_we  output  1  memory write strobe.
- mem_q  input  DATA_W  memory read data, valid one cycle after the address.

Behaviour:
- States: IDLE, OWN_CPU, OWN_DBG; state is registered.
- Grants are combinational from registered state: cpu_gnt = (state==OWN_CPU) & cpu_req; dbg_gnt likewise for OWN_DBG.
- Accept = req & gnt in the same cycle.
- IDLE:
  - No grants.
  - cpu_req only -> OWN_CPU; dbg_req only -> OWN_DBG.
  - Both requesting -> the requester that was NOT last_owner (round-robin); after reset last_owner = DBG, so the CPU wins the first tie.
- Arbitration latency: one cycle from IDLE to the first grant.
- OWN_X:
  - Each accept increments hold_cnt (saturating at MAX_HOLD).
  - Owner req low -> go to OWN_Y if the other requests, else IDLE; hold_cnt := 0.
  - hold_cnt reaches MAX_HOLD after an accept while the other requests -> switch to OWN_Y; hold_cnt := 0.
  - Other not requesting -> the owner keeps the grant indefinitely; hold_cnt saturates.
- last_owner is updated on every entry into OWN_X.
- Memory side:
  - mem_addr/mem_wdata are the current owner's inputs (CPU's in IDLE).
  - mem_we = accept & owner_we; mem_we is never high without a grant.
- Reads:
  - On an accepted read, rd_pending and rd_tag (owner) are registered.
  - Next cycle, the tagged port gets rvalid=1 and rdata=mem_q; the other port gets rvalid=0.
  - rdata holds its last value when rvalid=0.
- Back-to-back reads by alternating owners return in issue order; no overlap is possible because latency is fixed at 1.
- Reset values, asserted asynchronously:
  - state=IDLE, hold_cnt=0, last_owner=DBG.
  - rd_pending=0, so both rvalid=0.
  - Both rdata=0, mem_we=0, both gnt=0.
- Reset mid-operation: an outstanding read is dropped (no rvalid after reset release); any write not yet clocked is discarded.
- Requester deasserting req without a grant is legal; nothing is issued.

Optional Feature:
- Macro: MEM_ARB_DBG_LOCK_EN.
- Defined:
  - Adds input dbg_lock (1).
  - While state==OWN_DBG and dbg_lock=1, the MAX_HOLD switch is suppressed and the FSM stays in OWN_DBG even if dbg_req drops, so the CPU is starved and cpu_stall holds. This is used to halt the CPU for program loading.
  - Release is a normal transition evaluated on the cycle dbg_lock falls.
  - dbg_lock in any other state is ignored.
- Undefined: no dbg_lock port; fairness rule always applies.

Decomposition:
- Package mem_arb_pkg:
  - state typedef (IDLE/OWN_CPU/OWN_DBG).
  - owner typedef (CPU=0, DBG=1).
  - Default-width constants.
- One sub-module, arb_hold_counter: saturating counter with clear/increment and a reached-max flag, parameterised by MAX_HOLD.

Test Plan:
- Reset:
  - Stimulus: reset low mid-cycle with a read accepted on the previous edge.
  - Required: gnt/rvalid/mem_we go 0 immediately, state IDLE, no rvalid after release.
- CPU read:
  - Stimulus: cpu_req=1, cpu_we=0, cpu_addr=0x0010, mem[0x10]=0xBEEF.
  - Required: cycle 1 IDLE; cycle 2 cpu_gnt=1, mem_addr=0x0010; cycle 3 cpu_rvalid=1, cpu_rdata=0xBEEF, dbg_rvalid=0.
- Simultaneous requests from reset:
  - Stimulus: both req=1 continuously.
  - Required: CPU wins; exactly 4 CPU accepts, then 4 DBG accepts, alternating; cpu_stall=1 during DBG ownership.
- Write/read crossing ports:
  - Stimulus: dbg write 0x1234 to 0x0020, then CPU read 0x0020.
  - Required: mem_we pulses exactly one cycle with the dbg grant; CPU read returns 0x1234.
- Owner drops request:
  - Stimulus: CPU owner drops cpu_req while dbg_req=1.
  - Required: next cycle OWN_DBG, dbg_gnt=1, hold_cnt=0.
- With MEM_ARB_DBG_LOCK_EN:
  - Stimulus: dbg_lock=1 in OWN_DBG with cpu_req=1 for 10 cycles.
  - Required: cpu_gnt stays 0 and cpu_stall=1 throughout; first cpu_gnt one cycle after dbg_lock falls, once dbg_req is low.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DBG = 2'd2
    } arb_state_t;

    typedef enum logic {
        CPU = 1'b0,
        DBG = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating count of consecutive accepts by the current owner.
// max_on_inc is high when one more accept brings the count to MAX_HOLD.
module arb_hold_counter #(
    parameter int MAX_HOLD = 4,
    localparam int CNT_W = $clog2(MAX_HOLD + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic max_on_inc
);

    localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] count_r;

    // Count register: clear wins over increment, increment saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != MAX_VAL)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign max_on_inc = (count_r >= LAST_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / debug) arbiter for a single one-cycle-latency memory port.
// Optional MEM_ARB_DBG_LOCK_EN adds dbg_lock, which pins ownership to the debug port.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
`ifdef MEM_ARB_DBG_LOCK_EN
    input  logic              dbg_lock,
`endif
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    arb_state_t        state_r, state_next_s;
    owner_t            last_owner_r, last_owner_next_s;
    owner_t            owner_s, rd_tag_r;
    logic              rd_pending_r;
    logic [DATA_W-1:0] cpu_rdata_r, dbg_rdata_r;
    logic              accept_s, owner_we_s, lock_s, max_on_inc_s, cnt_clr_s;

`ifdef MEM_ARB_DBG_LOCK_EN
    assign lock_s = dbg_lock;
`else
    assign lock_s = 1'b0;
`endif

    assign cpu_gnt    = (state_r == OWN_CPU) & cpu_req;
    assign dbg_gnt    = (state_r == OWN_DBG) & dbg_req;
    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign accept_s   = cpu_gnt | dbg_gnt;
    assign owner_we_s = (owner_s == DBG) ? dbg_we : cpu_we;
    assign mem_addr   = (owner_s == DBG) ? dbg_addr : cpu_addr;
    assign mem_wdata  = (owner_s == DBG) ? dbg_wdata : cpu_wdata;
    assign mem_we     = accept_s & owner_we_s;

    // Read return: mem_q is passed through while valid, otherwise the last value holds.
    assign cpu_rvalid = rd_pending_r & (rd_tag_r == CPU);
    assign dbg_rvalid = rd_pending_r & (rd_tag_r == DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_q : cpu_rdata_r;
    assign dbg_rdata  = dbg_rvalid ? mem_q : dbg_rdata_r;

    // Current memory owner; the CPU drives the port while idle.
    always_comb begin
        owner_s = CPU;
        if (state_r == OWN_DBG) begin
            owner_s = DBG;
        end else begin
            owner_s = CPU;
        end
    end

    // Next-state and round-robin bookkeeping.
    always_comb begin
        state_next_s      = state_r;
        last_owner_next_s = last_owner_r;
        case (state_r)
            IDLE: begin
                if (cpu_req && dbg_req) begin
                    state_next_s = (last_owner_r == CPU) ? OWN_DBG : OWN_CPU;
                end else if (cpu_req) begin
                    state_next_s = OWN_CPU;
                end else if (dbg_req) begin
                    state_next_s = OWN_DBG;
                end else begin
                    state_next_s = IDLE;
                end
            end
            OWN_CPU: begin
                if (!cpu_req) begin
                    state_next_s = dbg_req ? OWN_DBG : IDLE;
                end else if (accept_s && max_on_inc_s && dbg_req) begin
                    state_next_s = OWN_DBG;
                end else begin
                    state_next_s = OWN_CPU;
                end
            end
            OWN_DBG: begin
                if (lock_s) begin
                    state_next_s = OWN_DBG;
                end else if (!dbg_req) begin
                    state_next_s = cpu_req ? OWN_CPU : IDLE;
                end else if (accept_s && max_on_inc_s && cpu_req) begin
                    state_next_s = OWN_CPU;
                end else begin
                    state_next_s = OWN_DBG;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        if ((state_next_s != state_r) && (state_next_s == OWN_CPU)) begin
            last_owner_next_s = CPU;
        end else if ((state_next_s != state_r) && (state_next_s == OWN_DBG)) begin
            last_owner_next_s = DBG;
        end else begin
            last_owner_next_s = last_owner_r;
        end
    end

    // Every ownership change restarts the burst count.
    assign cnt_clr_s = (state_next_s != state_r);

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk        (CLK),
        .rst_n      (reset),
        .clr        (cnt_clr_s),
        .inc        (accept_s),
        .max_on_inc (max_on_inc_s)
    );

    // Ownership state and last owner.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            last_owner_r <= DBG;
        end else begin
            state_r      <= state_next_s;
            last_owner_r <= last_owner_next_s;
        end
    end

    // Outstanding-read tracking and held read data.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd_pending_r <= 1'b0;
            rd_tag_r     <= CPU;
            cpu_rdata_r  <= '0;
            dbg_rdata_r  <= '0;
        end else begin
            rd_pending_r <= accept_s & ~owner_we_s;
            rd_tag_r     <= owner_s;
            cpu_rdata_r  <= cpu_rvalid ? mem_q : cpu_rdata_r;
            dbg_rdata_r  <= dbg_rvalid ? mem_q : dbg_rdata_r;
        end
    end

endmodule
